// File: rtl/seq_divider_8bit_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package seq_divider_8bit_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_divider_8bit_if.sv
// Start/busy/done request and result bundle for the divide path.
interface seq_divider_8bit_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider_8bit_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module seq_divider_8bit_div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);
    logic [WIDTH-1:0] rem_shifted;
    logic [WIDTH:0]   trial;

    // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
    always_comb begin
        rem_shifted = {rem[WIDTH-2:0], bit_in};
        trial       = {1'b0, rem_shifted} - {1'b0, divisor};
        // A set rem MSB means the shifted value already exceeds any divisor.
        q_bit       = rem[WIDTH-1] | ~trial[WIDTH];
        rem_next    = q_bit ? trial[WIDTH-1:0] : rem_shifted;
    end
endmodule

// File: rtl/seq_divider_8bit.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
module seq_divider_8bit
    import seq_divider_8bit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    seq_divider_8bit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] dvsr_r;
    logic [CW-1:0]    count;

    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] q_next;
    logic             q_bit;

    seq_divider_8bit_div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_r),
        .bit_in   (q_r[WIDTH-1]),
        .divisor  (dvsr_r),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    assign q_next = {q_r[WIDTH-2:0], q_bit};

    // NOTE: state and registered outputs use non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            rem_r           <= '0;
            q_r             <= '0;
            dvsr_r          <= '0;
            count           <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start && bus.divisor != '0) begin
                        dvsr_r   <= bus.divisor;
                        rem_r    <= '0;
                        q_r      <= bus.dividend;
                        count    <= '0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end else if (bus.start) begin
                        bus.quotient    <= '1;
                        bus.remainder   <= bus.dividend;
                        bus.div_by_zero <= 1'b1;
                        bus.done        <= 1'b1;
                        state           <= DONE;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    rem_r <= rem_next;
                    q_r   <= q_next;
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        bus.quotient    <= q_next;
                        bus.remainder   <= rem_next;
                        bus.div_by_zero <= 1'b0;
                        bus.busy        <= 1'b0;
                        bus.done        <= 1'b1;
                        state           <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
